skin_pipe_ctrl: RTL and testbench

//  Frame-level sequencer for the fixed-latency YCbCr skin-tone detector pipeline.

---
 rtl/skin_pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_skin_pipe_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skin_pipe_ctrl.sv
// skin_pipe_ctrl: frame sequencer for a fixed-latency, non-stallable skin-tone
// detector. Pixels are issued only while credit remains. Credit is the FIFO
// space not already claimed by buffered or in-flight scores, so every score
// that leaves the detector has a FIFO slot waiting for it.
module skin_pipe_ctrl #(
    parameter  int LATENCY      = 4,
    parameter  int FIFO_DEPTH   = 8,
    parameter  int FRAME_PIXELS = 76800,
    parameter  int SCORE_TH     = 128,
    localparam int CW           = $clog2(FRAME_PIXELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [7:0]    pix_Y,
    input  logic [7:0]    pix_Cb,
    input  logic [7:0]    pix_Cr,
    output logic          det_valid,
    output logic [7:0]    det_Y,
    output logic [7:0]    det_Cb,
    output logic [7:0]    det_Cr,
    input  logic [7:0]    det_score,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_score,
    output logic          out_last,
    output logic          frame_done,
    output logic [CW-1:0] skin_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // One tag per detector stage: does this stage carry a real pixel, and is
    // it the final pixel of the frame.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    typedef struct packed {
        logic       last;
        logic [7:0] score;
    } entry_t;

    state_t             state_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [CW-1:0]      skin_count_q;
    logic [CW-1:0]      issue_cnt_q;
    logic [CW-1:0]      skin_acc_q;

    tag_t [LATENCY-1:0] tag_q;
    logic [IW-1:0]      inflight_q, inflight_d;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]      fifo_count_q, fifo_count_d;

    logic [SW-1:0]      occupancy;
    logic               issue_last;
    logic               push;
    logic               pop;
    logic               skin_hit;
    logic               drained;

    // Detector inputs are a straight copy of the upstream pixel.
    assign det_Y  = pix_Y;
    assign det_Cb = pix_Cb;
    assign det_Cr = pix_Cr;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign skin_count = skin_count_q;

    assign out_valid = (fifo_count_q != '0);
    assign out_score = fifo_mem[rd_ptr_q].score;
    assign out_last  = out_valid && fifo_mem[rd_ptr_q].last;

    // Credit check, handshakes and next-state occupancy counts.
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    always_comb begin
        occupancy    = SW'(fifo_count_q) + SW'(inflight_q);
        pix_ready    = (state_q == RUN) && (occupancy < SW'(FIFO_DEPTH));
        det_valid    = pix_valid && pix_ready;
        issue_last   = det_valid && (issue_cnt_q == CW'(FRAME_PIXELS - 1));
        push         = tag_q[LATENCY-1].valid;
        pop          = out_valid && out_ready;
        skin_hit     = push && (det_score >= 8'(SCORE_TH));
        inflight_d   = inflight_q + IW'(det_valid) - IW'(push);
        fifo_count_d = fifo_count_q + NW'(push) - NW'(pop);
        drained      = (inflight_q == '0) && (fifo_count_d == '0);
    end

    // Frame FSM with registered busy / frame_done / skin_count outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            skin_count_q <= '0;
            issue_cnt_q  <= '0;
            skin_acc_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (det_valid) begin
                issue_cnt_q <= issue_cnt_q + CW'(1);
            end
            if (skin_hit) begin
                skin_acc_q <= skin_acc_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    // A start landing on the frame_done cycle is dropped.
                    if (start && !frame_done_q) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                        skin_acc_q  <= '0;
                    end
                end
                RUN: begin
                    if (issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        skin_count_q <= skin_acc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag shift register tracking the detector stages, plus FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q        <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            assert (!(push && (fifo_count_q == NW'(FIFO_DEPTH))));
            tag_q[0] <= tag_t'{valid: det_valid, last: issue_last};
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Score storage, written whenever a tagged score leaves the detector.
    // NOTE: the array itself has no reset; pointers and count are reset, so
    // stale entries are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= entry_t'{last: tag_q[LATENCY-1].last, score: det_score};
        end
    end

endmodule

// File: tb/tb_skin_pipe_ctrl.sv
// Bench for skin_pipe_ctrl: two instances (score FIFO of 8 and of 2 entries)
// share the stimulus. A frame-level scoreboard predicts the selected one.
module tb_skin_pipe_ctrl;

    localparam int LAT = 4;
    localparam int FP  = 4;
    localparam int TH  = 128;
    localparam int CW  = $clog2(FP + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] pix_Y = '0, pix_Cb = '0, pix_Cr = '0;
    logic [7:0] det_score;
    logic [7:0] det_pipe [LAT];

    // Detector stand-in: the score is the Y component, delayed LAT cycles,
    // shifting every cycle whether or not a pixel was issued.
    always @(posedge clk) begin
        det_pipe[0] <= pix_Y;
        for (int i = 1; i < LAT; i++) det_pipe[i] <= det_pipe[i-1];
    end
    assign det_score = det_pipe[LAT-1];

    logic          a_busy, a_pix_ready, a_det_valid, a_out_valid, a_out_last, a_frame_done;
    logic [7:0]    a_det_Y, a_det_Cb, a_det_Cr, a_out_score;
    logic [CW-1:0] a_skin;
    logic          b_busy, b_pix_ready, b_det_valid, b_out_valid, b_out_last, b_frame_done;
    logic [7:0]    b_det_Y, b_det_Cb, b_det_Cr, b_out_score;
    logic [CW-1:0] b_skin;

    skin_pipe_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(8), .FRAME_PIXELS(FP), .SCORE_TH(TH)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy),
        .pix_valid(pix_valid), .pix_ready(a_pix_ready),
        .pix_Y(pix_Y), .pix_Cb(pix_Cb), .pix_Cr(pix_Cr),
        .det_valid(a_det_valid), .det_Y(a_det_Y), .det_Cb(a_det_Cb), .det_Cr(a_det_Cr),
        .det_score(det_score), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_score(a_out_score), .out_last(a_out_last), .frame_done(a_frame_done),
        .skin_count(a_skin)
    );

    skin_pipe_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(2), .FRAME_PIXELS(FP), .SCORE_TH(TH)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(b_busy),
        .pix_valid(pix_valid), .pix_ready(b_pix_ready),
        .pix_Y(pix_Y), .pix_Cb(pix_Cb), .pix_Cr(pix_Cr),
        .det_valid(b_det_valid), .det_Y(b_det_Y), .det_Cb(b_det_Cb), .det_Cr(b_det_Cr),
        .det_score(det_score), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_score(b_out_score), .out_last(b_out_last), .frame_done(b_frame_done),
        .skin_count(b_skin)
    );

    logic          use2 = 1'b0;
    logic          busy, pix_ready, det_valid, out_valid, out_last, frame_done;
    logic [7:0]    det_Y, det_Cb, det_Cr, out_score;
    logic [CW-1:0] skin_count;
    assign busy       = use2 ? b_busy       : a_busy;
    assign pix_ready  = use2 ? b_pix_ready  : a_pix_ready;
    assign det_valid  = use2 ? b_det_valid  : a_det_valid;
    assign out_valid  = use2 ? b_out_valid  : a_out_valid;
    assign out_last   = use2 ? b_out_last   : a_out_last;
    assign frame_done = use2 ? b_frame_done : a_frame_done;
    assign det_Y      = use2 ? b_det_Y      : a_det_Y;
    assign det_Cb     = use2 ? b_det_Cb     : a_det_Cb;
    assign det_Cr     = use2 ? b_det_Cr     : a_det_Cr;
    assign out_score  = use2 ? b_out_score  : a_out_score;
    assign skin_count = use2 ? b_skin       : a_skin;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each issued pixel becomes visible at the output LAT+1 cycles
    // after its issue, in issue order, and the FP-th issue of a frame is last.
    typedef struct {
        int         rdy;
        logic [7:0] score;
        bit         last;
    } ent_t;
    ent_t sb[$];

    bit m_active = 1'b0, m_done = 1'b0;
    int m_issued = 0, m_popped = 0, m_skin = 0, m_skin_reg = 0;
    int dv_seen = 0, pop_seen = 0, done_seen = 0;

    task automatic step(input bit r, input bit st, input bit pv, input bit ordy, input logic [7:0] y);
        int depth;
        bit exp_ready, exp_dv, exp_ov, honoured, last_pop;
        @(posedge clk);
        #1;
        rst = r; start = st; pix_valid = pv; out_ready = ordy; pix_Y = y;
        pix_Cb = 8'($urandom); pix_Cr = 8'($urandom);
        #1;
        depth     = use2 ? 2 : 8;
        exp_ready = m_active && (m_issued < FP) && ((m_issued - m_popped) < depth);
        exp_dv    = pv && exp_ready;
        exp_ov    = (sb.size() > 0) && (sb[0].rdy <= cyc);
        if (det_valid === 1'b1) dv_seen++;
        if (out_valid === 1'b1 && ordy) pop_seen++;
        if (frame_done === 1'b1) done_seen++;
        if (chk_en) begin
            check("busy", busy, m_active);
            check("pix_ready", pix_ready, exp_ready);
            check("det_valid", det_valid, exp_dv);
            check("out_valid", out_valid, exp_ov);
            check("frame_done", frame_done, m_done);
            check("skin_count", skin_count, m_skin_reg);
            if (exp_dv) begin
                check("det_Y", det_Y, pix_Y);
                check("det_Cb", det_Cb, pix_Cb);
                check("det_Cr", det_Cr, pix_Cr);
            end
            if (exp_ov) begin
                check("out_score", out_score, sb[0].score);
                check("out_last", out_last, sb[0].last);
            end else begin
                check("out_last_idle", out_last, 0);
            end
        end
        if (r) begin
            m_active = 1'b0; m_done = 1'b0; m_skin_reg = 0;
            m_issued = 0; m_popped = 0; m_skin = 0;
            sb.delete();
        end else begin
            honoured = st && !m_active && !m_done;
            last_pop = 1'b0;
            if (exp_dv) begin
                sb.push_back(ent_t'{rdy: cyc + LAT + 1, score: y, last: (m_issued == FP - 1)});
                m_issued++;
                if (y >= TH) m_skin++;
            end
            if (exp_ov && ordy) begin
                sb.delete(0);
                m_popped++;
                last_pop = (m_popped == FP);
            end
            if (honoured) begin
                m_active = 1'b1; m_issued = 0; m_popped = 0; m_skin = 0;
            end
            if (last_pop) begin
                m_active   = 1'b0;
                m_skin_reg = m_skin;
            end
            m_done = last_pop;
        end
        cyc++;
    endtask

    // Reset both instances and select one; the first reset cycle is unchecked
    // because the selected instance may hold leftovers of shared stimulus.
    task automatic select_dut(input bit d);
        use2   = d;
        chk_en = 1'b0;
        step(1, 0, 0, 0, 8'd0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 8'd0);
    endtask

    // Run until frame_done is seen, bounded by a cycle budget.
    task automatic drain(input int bound, input bit pv, input bit toggle);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < bound && done_seen == d0; i++) begin
            step(0, 0, pv, toggle ? bit'(i % 2) : 1'b1, 8'($urandom));
        end
        check("drain_frame_done_seen", done_seen - d0, 1);
    endtask

    typedef struct {
        bit         st;
        bit         pv;
        logic [7:0] y;
        bit         busy;
        bit         rdy;
        bit         ov;
        logic [7:0] score;
        bit         last;
        bit         done;
        int         skin;
    } vec_t;
    vec_t t1[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t1[0]  = '{1, 0, 8'd0,   0, 0, 0, 8'd0,   0, 0, 0};
        t1[1]  = '{0, 1, 8'd10,  1, 1, 0, 8'd0,   0, 0, 0};
        t1[2]  = '{0, 1, 8'd200, 1, 1, 0, 8'd0,   0, 0, 0};
        t1[3]  = '{0, 1, 8'd128, 1, 1, 0, 8'd0,   0, 0, 0};
        t1[4]  = '{0, 1, 8'd127, 1, 1, 0, 8'd0,   0, 0, 0};
        t1[5]  = '{0, 0, 8'd0,   1, 0, 0, 8'd0,   0, 0, 0};
        t1[6]  = '{0, 0, 8'd0,   1, 0, 1, 8'd10,  0, 0, 0};
        t1[7]  = '{0, 0, 8'd0,   1, 0, 1, 8'd200, 0, 0, 0};
        t1[8]  = '{0, 0, 8'd0,   1, 0, 1, 8'd128, 0, 0, 0};
        t1[9]  = '{0, 0, 8'd0,   1, 0, 1, 8'd127, 1, 0, 0};
        t1[10] = '{1, 0, 8'd0,   0, 0, 0, 8'd0,   0, 1, 2};
        t1[11] = '{0, 0, 8'd0,   0, 0, 0, 8'd0,   0, 0, 2};

        // T1: one back-to-back frame; start coincident with frame_done is dropped.
        select_dut(0);
        for (int i = 0; i < 12; i++) begin
            step(0, t1[i].st, t1[i].pv, 1, t1[i].y);
            check("t1_busy", busy, t1[i].busy);
            check("t1_pix_ready", pix_ready, t1[i].rdy);
            check("t1_out_valid", out_valid, t1[i].ov);
            check("t1_frame_done", frame_done, t1[i].done);
            check("t1_skin_count", skin_count, t1[i].skin);
            check("t1_out_last", out_last, t1[i].last);
            if (t1[i].ov) check("t1_out_score", out_score, t1[i].score);
        end

        // T2: two-entry FIFO with downstream stalled, then released.
        select_dut(1);
        dv_seen = 0; pop_seen = 0;
        step(0, 1, 0, 0, 8'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 8'($urandom));
        check("t2_issued_while_stalled", dv_seen, 2);
        check("t2_pix_ready_low", pix_ready, 0);
        drain(60, 1, 0);
        check("t2_issued_total", dv_seen, 4);
        check("t2_delivered", pop_seen, 4);

        // T3: gaps in pix_valid.
        select_dut(0);
        dv_seen = 0; pop_seen = 0;
        step(0, 1, 0, 1, 8'd0);
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) step(0, 0, pat[i], 1, 8'($urandom));
        end
        drain(40, 0, 0);
        check("t3_issued", dv_seen, 4);
        check("t3_delivered", pop_seen, 4);

        // T4: start during RUN and DRAIN ignored; skin_count holds across frames.
        step(0, 1, 0, 1, 8'd0);
        step(0, 1, 1, 1, 8'd200);
        step(0, 0, 1, 1, 8'd200);
        step(0, 1, 1, 1, 8'd200);
        step(0, 0, 1, 1, 8'd5);
        step(0, 1, 0, 1, 8'd0);
        step(0, 1, 0, 1, 8'd0);
        drain(40, 0, 0);
        check("t4_skin_a", skin_count, 3);
        step(0, 1, 0, 1, 8'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'd10);
        check("t4_skin_hold", skin_count, 3);
        check("t4_busy_second_frame", busy, 1);
        drain(40, 0, 0);
        check("t4_skin_b", skin_count, 0);

        // T5: reset two cycles after the second issue discards the frame.
        step(0, 1, 0, 1, 8'd0);
        step(0, 0, 1, 1, 8'd200);
        step(0, 0, 1, 1, 8'd200);
        step(0, 0, 0, 1, 8'd0);
        step(1, 0, 0, 1, 8'd0);
        step(0, 0, 0, 1, 8'd0);
        check("t5_out_valid_after_rst", out_valid, 0);
        check("t5_busy_after_rst", busy, 0);
        pop_seen = 0; done_seen = 0;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 8'd0);
        check("t5_no_late_scores", pop_seen, 0);
        check("t5_no_frame_done", done_seen, 0);

        // T6: two-entry FIFO, out_ready toggling every cycle.
        select_dut(1);
        dv_seen = 0; pop_seen = 0;
        step(0, 1, 0, 0, 8'd0);
        drain(80, 1, 1);
        check("t6_issued", dv_seen, 4);
        check("t6_delivered", pop_seen, 4);

        // Randomised traffic on both instances against the scoreboard.
        for (int d = 0; d < 2; d++) begin
            select_dut(bit'(d));
            done_seen = 0;
            for (int i = 0; i < 800; i++) begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 8'($urandom));
            end
            check("rand_frames_completed", done_seen > 2, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
